// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: CPU and program loader share one memory port.
// Round-robin on ties; each grant runs IDLE -> ACCESS (LAT cycles) -> DONE.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              last_ld;
  logic              grant_ld;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              pick_ld;

  // Loader wins only when alone or when the CPU had the previous grant.
  assign pick_ld = ld_req && (!cpu_req || !last_ld);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last_ld  <= 1'b1;
      grant_ld <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      rdata_r  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cpu_req || ld_req) begin
            grant_ld <= pick_ld;
            last_ld  <= pick_ld;
            we_r     <= pick_ld ? ld_we    : cpu_we;
            addr_r   <= pick_ld ? ld_addr  : cpu_addr;
            wdata_r  <= pick_ld ? ld_wdata : cpu_wdata;
            cnt      <= LAT_M1;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!we_r) rdata_r <= mem_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    cpu_done  = 1'b0;
    ld_done   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (cpu_req || ld_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = we_r;
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        cpu_done  = !grant_ld;
        ld_done   = grant_ld;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign rdata     = rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: LAT=2 main instance, LAT=1 second instance.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ld_req, ld_we;
  logic [7:0]  cpu_addr, ld_addr;
  logic [15:0] cpu_wdata, ld_wdata, mem_rdata;
  logic        cpu_done, ld_done, mem_en, mem_we, busy;
  logic [15:0] rdata, mem_wdata;
  logic [7:0]  mem_addr;

  logic        cpu_req1, ld_req1;
  logic        cpu_done1, ld_done1, mem_en1, mem_we1, busy1;
  logic [15:0] rdata1, mem_wdata1;
  logic [7:0]  mem_addr1;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .LAT(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .LAT(1)) dut_lat1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req1), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done1),
    .ld_req(ld_req1), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done1),
    .rdata(rdata1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cpu_req = 1'b0; ld_req = 1'b0; cpu_req1 = 1'b0; ld_req1 = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cpu_req = 1'b1; ld_req = 1'b1;
    tick(); tick();
    do_reset();
    tests_run++;
    if ({busy, mem_en, mem_we, cpu_done, ld_done} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 00000", {busy, mem_en, mem_we, cpu_done, ld_done});
    end
    tests_run++;
    if (rdata !== 16'h0 || mem_addr !== 8'h0 || mem_wdata !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: rdata=%h addr=%h wdata=%h, expected all 0", rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_cpu_read();
    int en_cnt = 0, done_c = -1, bad = 0;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; mem_rdata = 16'hBEEF;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (mem_en) begin
        en_cnt++;
        if (mem_addr !== 8'h10 || mem_we !== 1'b0) bad++;
      end
      if (ld_done) bad++;
      if (cpu_done) begin
        done_c = c; cpu_req = 1'b0;
        tests_run++;
        if (rdata !== 16'hBEEF) begin
          tests_failed++;
          $display("[TB] FAIL cpu_read_rdata: got %h, expected beef", rdata);
        end
      end
    end
    tests_run++;
    if (en_cnt !== 2) begin
      tests_failed++;
      $display("[TB] FAIL cpu_read_en_cycles: got %0d, expected 2", en_cnt);
    end
    tests_run++;
    if (done_c !== 3) begin
      tests_failed++;
      $display("[TB] FAIL cpu_read_done_cycle: got %0d, expected 3", done_c);
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL cpu_read_bus: %0d bad cycles, expected 0", bad);
    end
  endtask

  task automatic test_both();
    int cpu_c = -1, ld_c = -1, overlap = 0;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h20;
    mem_rdata = 16'hBEEF;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (cpu_done && ld_done) overlap++;
      if (c == 5) begin
        tests_run++;
        if (mem_en !== 1'b1 || mem_addr !== 8'h20) begin
          tests_failed++;
          $display("[TB] FAIL both_second_grant: en=%b addr=%h, expected 1/20", mem_en, mem_addr);
        end
      end
      if (cpu_done) begin cpu_c = c; cpu_req = 1'b0; end
      if (ld_done)  begin ld_c = c;  ld_req = 1'b0;  end
    end
    tests_run++;
    if (cpu_c !== 3) begin
      tests_failed++;
      $display("[TB] FAIL both_cpu_first: cpu_done cycle %0d, expected 3", cpu_c);
    end
    tests_run++;
    if (ld_c !== 7) begin
      tests_failed++;
      $display("[TB] FAIL both_ld_spacing: ld_done cycle %0d, expected 7", ld_c);
    end
    tests_run++;
    if (overlap !== 0) begin
      tests_failed++;
      $display("[TB] FAIL both_done_overlap: %0d cycles, expected 0", overlap);
    end
  endtask

  // Runs right after test_both, whose last completed read left 0xBEEF in rdata.
  task automatic test_ld_write();
    int we_ok = 0, we_bad = 0, done_c = -1;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h3F; ld_wdata = 16'h1234;
    mem_rdata = 16'h5555;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (mem_we && mem_en && mem_addr === 8'h3F && mem_wdata === 16'h1234) we_ok++;
      if (mem_we && !mem_en) we_bad++;
      if (ld_done) begin done_c = c; ld_req = 1'b0; end
    end
    tests_run++;
    if (we_ok !== 2 || we_bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL ld_write_bus: good=%0d bad=%0d, expected 2/0", we_ok, we_bad);
    end
    tests_run++;
    if (done_c !== 3) begin
      tests_failed++;
      $display("[TB] FAIL ld_write_done: cycle %0d, expected 3", done_c);
    end
    tests_run++;
    if (rdata !== 16'hBEEF) begin
      tests_failed++;
      $display("[TB] FAIL ld_write_rdata: got %h, expected beef", rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic seq [6];
    int n = 0, overlap = 0;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; ld_req = 1'b1; ld_we = 1'b0;
    for (int c = 1; c <= 40 && n < 6; c++) begin
      tick();
      if (cpu_done && ld_done) overlap++;
      if (cpu_done || ld_done) begin
        seq[n] = ld_done;
        n++;
      end
    end
    cpu_req = 1'b0; ld_req = 1'b0;
    tests_run++;
    if (n !== 6) begin
      tests_failed++;
      $display("[TB] FAIL rr_grant_count: got %0d, expected 6", n);
    end
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (seq[i] !== 1'(i % 2)) begin
        tests_failed++;
        $display("[TB] FAIL rr_grant_%0d: ld=%b, expected %b", i, seq[i], 1'(i % 2));
      end
    end
    tests_run++;
    if (overlap !== 0) begin
      tests_failed++;
      $display("[TB] FAIL rr_done_overlap: %0d cycles, expected 0", overlap);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0;
    tick();
    tick();
    tests_run++;
    if (mem_en !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_pre: mem_en=%b, expected 1", mem_en);
    end
    reset = 1'b1; cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    tests_run++;
    if (mem_en !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_state: en=%b busy=%b, expected 0/0", mem_en, busy);
    end
    if (cpu_done || ld_done) dones++;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (cpu_done || ld_done || mem_en) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_abort: %0d activity cycles, expected 0", dones);
    end
  endtask

  task automatic test_lat1();
    int en_cnt = 0, done_c = -1;
    do_reset();
    cpu_req1 = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h44; mem_rdata = 16'hA5A5;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (mem_en1) en_cnt++;
      if (cpu_done1) begin done_c = c; cpu_req1 = 1'b0; end
    end
    tests_run++;
    if (en_cnt !== 1) begin
      tests_failed++;
      $display("[TB] FAIL lat1_en_cycles: got %0d, expected 1", en_cnt);
    end
    tests_run++;
    if (done_c !== 2) begin
      tests_failed++;
      $display("[TB] FAIL lat1_done_cycle: got %0d, expected 2", done_c);
    end
    tests_run++;
    if (rdata1 !== 16'hA5A5) begin
      tests_failed++;
      $display("[TB] FAIL lat1_rdata: got %h, expected a5a5", rdata1);
    end
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    cpu_req1 = 1'b0; ld_req1 = 1'b0; mem_rdata = '0;
    test_reset();
    test_cpu_read();
    test_both();
    test_ld_write();
    test_back_to_back();
    test_reset_mid();
    test_lat1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
